// File: rtl/cache_dm_if.sv
// Requester and backing-memory signals of the direct-mapped cache.
// slave is the cache side, master the requester/memory side.
interface cache_dm_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] q;
  logic              hit;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  req, wr, addr, data, mem_rdata, mem_ack,
    output ready, done, q, hit, mem_req, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
  modport master (
    output req, wr, addr, data, mem_rdata, mem_ack,
    input  ready, done, q, hit, mem_req, mem_wr, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_dm.sv
// Direct-mapped, write-through, write-allocate cache with single-word lines,
// a req/done handshake toward the requester and req/ack toward memory.
module cache_dm #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  cache_dm_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] line_data_q [LINES];
  logic [TAG_W-1:0]  line_tag_q  [LINES];

  logic              line_we;
  logic [IDX_W-1:0]  line_idx;
  logic [DATA_W-1:0] line_wdata;
  logic [TAG_W-1:0]  line_wtag;

  logic              hit_acc_q, hit_acc_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              hit_q, hit_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lookup_hit;
  logic              accept;

  assign req_idx    = bus.addr[IDX_W-1:0];
  assign req_tag    = bus.addr[ADDR_W-1:IDX_W];
  assign lookup_hit = valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
  assign bus.ready  = (state_q == IDLE) && !rst;
  assign accept     = bus.req && bus.ready;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    line_we     = 1'b0;
    line_idx    = req_idx;
    line_wdata  = bus.data;
    line_wtag   = req_tag;
    hit_acc_d   = hit_acc_q;
    done_d      = 1'b0;
    q_d         = q_q;
    hit_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hit_acc_d  = lookup_hit;
          mem_addr_d = bus.addr;
          if (!bus.wr && lookup_hit) begin
            done_d = 1'b1;
            q_d    = line_data_q[req_idx];
            hit_d  = 1'b1;
          end else if (!bus.wr) begin
            state_d   = RD_MEM;
            mem_req_d = 1'b1;
            mem_wr_d  = 1'b0;
          end else begin
            // write-allocate: the line is valid with new data before memory acks
            line_we           = 1'b1;
            valid_d[req_idx]  = 1'b1;
            state_d           = WR_MEM;
            mem_req_d         = 1'b1;
            mem_wr_d          = 1'b1;
            mem_wdata_d       = bus.data;
          end
        end
      end
      RD_MEM: begin
        if (bus.mem_ack) begin
          line_we           = 1'b1;
          line_idx          = mem_addr_q[IDX_W-1:0];
          line_wtag         = mem_addr_q[ADDR_W-1:IDX_W];
          line_wdata        = bus.mem_rdata;
          valid_d[line_idx] = 1'b1;
          done_d            = 1'b1;
          q_d               = bus.mem_rdata;
          mem_req_d         = 1'b0;
          state_d           = IDLE;
        end
      end
      WR_MEM: begin
        if (bus.mem_ack) begin
          done_d    = 1'b1;
          hit_d     = hit_acc_q;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_d) begin
      if (hit_d && !(&hit_cnt_q))        hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      else if (!hit_d && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      hit_acc_q   <= 1'b0;
      done_q      <= 1'b0;
      q_q         <= '0;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      hit_acc_q   <= hit_acc_d;
      done_q      <= done_d;
      q_q         <= q_d;
      hit_q       <= hit_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Data and tag storage is left unreset; valid_q guards it.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_data_q[line_idx] <= line_wdata;
      line_tag_q[line_idx]  <= line_wtag;
    end
  end

  assign bus.done      = done_q;
  assign bus.q         = q_q;
  assign bus.hit       = hit_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_dm.sv
// Bench for cache_dm: directed scenarios plus random traffic against an
// address-level model; a CNT_W=2 twin shares the stimulus to exercise saturation.
module tb_cache_dm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_dm_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) ifc ();
  cache_dm_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(2))  ifc_s ();

  cache_dm #(.DATA_W(32), .ADDR_W(10), .LINES(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  cache_dm #(.DATA_W(32), .ADDR_W(10), .LINES(16), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(ifc_s.slave));

  assign ifc_s.req       = ifc.req;
  assign ifc_s.wr        = ifc.wr;
  assign ifc_s.addr      = ifc.addr;
  assign ifc_s.data      = ifc.data;
  assign ifc_s.mem_rdata = ifc.mem_rdata;
  assign ifc_s.mem_ack   = ifc.mem_ack;

  int n_chk = 0, n_pass = 0;

  // Reference: backing memory contents and which full address each line holds.
  logic [31:0] mem [1024];
  int          cached [16];
  int          hits_m = 0, misses_m = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) cached[i] = -1;
    hits_m = 0; misses_m = 0;
  endfunction

  function automatic bit model_txn(input bit w, input int a, input logic [31:0] d);
    bit h;
    h = (cached[a % 16] == a);
    cached[a % 16] = a;
    if (w) mem[a] = d;
    if (h) hits_m++; else misses_m++;
    return h;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Issues one request and plays the memory with an ack dly cycles after mem_req rises.
  task automatic do_txn(input bit w, input logic [9:0] a, input logic [31:0] d, input int dly,
                        output bit ok, output logic [31:0] rq, output logic rh, output bit used_mem,
                        output logic mw, output logic [9:0] ma, output logic [31:0] md,
                        output int lat, output bit stable);
    int wc;
    ok = 0; rq = '0; rh = 1'b0; used_mem = 0; mw = 1'b0; ma = '0; md = '0; lat = 0; stable = 1; wc = 0;
    ifc.req = 1'b1; ifc.wr = w; ifc.addr = a; ifc.data = d;
    @(posedge clk); #1;
    ifc.req = 1'b0; lat = 1;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (ifc.done === 1'b1) begin
        ok = 1; rq = ifc.q; rh = ifc.hit;
      end else begin
        if (ifc.mem_req === 1'b1) begin
          if (!used_mem) begin
            used_mem = 1; mw = ifc.mem_wr; ma = ifc.mem_addr; md = ifc.mem_wdata;
          end else if (ifc.mem_addr !== ma || ifc.mem_wr !== mw || ifc.mem_wdata !== md) stable = 0;
          wc++;
          if (wc == dly) begin
            ifc.mem_ack = 1'b1;
            ifc.mem_rdata = mem[ifc.mem_addr];
          end
        end
        @(posedge clk); #1;
        ifc.mem_ack = 1'b0; ifc.mem_rdata = $urandom; lat++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_chk++; if (ifc.ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ifc.ready); else n_pass++;
    n_chk++;
    if ({ifc.done, ifc.q, ifc.hit, ifc.mem_req, ifc.mem_wr, ifc.mem_addr, ifc.mem_wdata, ifc.hit_cnt, ifc.miss_cnt} !== '0)
      $display("FAIL reset_outputs got done=%b q=%h hit=%b mreq=%b mwr=%b maddr=%h mwd=%h hc=%0d mc=%0d exp all 0",
               ifc.done, ifc.q, ifc.hit, ifc.mem_req, ifc.mem_wr, ifc.mem_addr, ifc.mem_wdata, ifc.hit_cnt, ifc.miss_cnt);
    else n_pass++;
  endtask

  task automatic test_write_miss();
    bit ok, um, st; logic [31:0] rq, md; logic rh, mw; logic [9:0] ma; int lat, eh;
    logic [9:0]  av [2] = '{10'd0, 10'd1};
    logic [31:0] dv [2] = '{32'h1, 32'h3};
    for (int i = 0; i < 2; i++) begin
      eh = model_txn(1'b1, av[i], dv[i]);
      do_txn(1'b1, av[i], dv[i], 3, ok, rq, rh, um, mw, ma, md, lat, st);
      n_chk++; if (!ok) $display("FAIL wr_done a=%0d no done seen", av[i]); else n_pass++;
      n_chk++; if ({um, mw, ma, md} !== {1'b1, 1'b1, av[i], dv[i]})
        $display("FAIL wr_mem a=%0d got req=%b wr=%b addr=%0d wdata=%h exp 1 1 %0d %h", av[i], um, mw, ma, md, av[i], dv[i]);
      else n_pass++;
      n_chk++; if (rh !== 1'(eh)) $display("FAIL wr_hit a=%0d got %b exp %0d", av[i], rh, eh); else n_pass++;
      n_chk++; if (lat != 4) $display("FAIL wr_latency a=%0d got %0d exp 4", av[i], lat); else n_pass++;
      n_chk++; if (!st) $display("FAIL wr_mem_stable a=%0d got unstable exp stable", av[i]); else n_pass++;
    end
    n_chk++; if (ifc.miss_cnt !== 16'(misses_m)) $display("FAIL miss_cnt got %0d exp %0d", ifc.miss_cnt, misses_m); else n_pass++;
  endtask

  task automatic test_read_hit();
    bit ok, um, st; logic [31:0] rq, md; logic rh, mw; logic [9:0] ma; int lat, eh;
    logic [9:0] av [2] = '{10'd1, 10'd0};
    for (int i = 0; i < 2; i++) begin
      eh = model_txn(1'b0, av[i], '0);
      do_txn(1'b0, av[i], '0, 2, ok, rq, rh, um, mw, ma, md, lat, st);
      n_chk++; if (rq !== mem[av[i]]) $display("FAIL rdhit_q a=%0d got %h exp %h", av[i], rq, mem[av[i]]); else n_pass++;
      n_chk++; if ({rh, um} !== {1'(eh), 1'b0}) $display("FAIL rdhit_flags a=%0d got hit=%b memreq=%b exp %0d 0", av[i], rh, um, eh); else n_pass++;
      n_chk++; if (lat != 1) $display("FAIL rdhit_latency a=%0d got %0d exp 1", av[i], lat); else n_pass++;
    end
    n_chk++; if (ifc.hit_cnt !== 16'(hits_m)) $display("FAIL hit_cnt got %0d exp %0d", ifc.hit_cnt, hits_m); else n_pass++;
  endtask

  task automatic test_cold_and_conflict();
    bit ok, um, st; logic [31:0] rq, md; logic rh, mw; logic [9:0] ma; int lat, eh;
    logic [9:0] av [5] = '{10'd5, 10'd5, 10'd2, 10'd18, 10'd2};
    bit         wv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mem[5] = 32'hDEAD; mem[18] = 32'hB;
    for (int i = 0; i < 5; i++) begin
      eh = model_txn(wv[i], av[i], 32'hA);
      do_txn(wv[i], av[i], 32'hA, 2, ok, rq, rh, um, mw, ma, md, lat, st);
      n_chk++; if (rh !== 1'(eh)) $display("FAIL cc_hit i=%0d a=%0d got %b exp %0d", i, av[i], rh, eh); else n_pass++;
      if (!wv[i]) begin
        n_chk++; if (rq !== mem[av[i]]) $display("FAIL cc_q i=%0d a=%0d got %h exp %h", i, av[i], rq, mem[av[i]]); else n_pass++;
      end
      if (!eh || wv[i]) begin
        n_chk++; if ({um, mw, ma} !== {1'b1, wv[i], av[i]})
          $display("FAIL cc_mem i=%0d got req=%b wr=%b addr=%0d exp 1 %b %0d", i, um, mw, ma, wv[i], av[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] av [3] = '{10'd5, 10'd1, 10'd0};
    int eh;
    ifc.req = 1'b1; ifc.wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eh = model_txn(1'b0, av[i], '0);
      ifc.addr = av[i];
      n_chk++; if (ifc.ready !== 1'b1) $display("FAIL b2b_ready i=%0d got %b exp 1", i, ifc.ready); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if ({ifc.done, ifc.hit, ifc.q} !== {1'b1, 1'(eh), mem[av[i]]})
        $display("FAIL b2b_done i=%0d got done=%b hit=%b q=%h exp 1 %0d %h", i, ifc.done, ifc.hit, ifc.q, eh, mem[av[i]]);
      else n_pass++;
    end
    ifc.req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (ifc.done !== 1'b0) $display("FAIL b2b_done_pulse got %b exp 0", ifc.done); else n_pass++;
  endtask

  task automatic test_saturate();
    bit ok, um, st; logic [31:0] rq, md; logic rh, mw; logic [9:0] ma; int lat, eh;
    for (int i = 0; i < 5; i++) begin
      eh = model_txn(1'b0, 10'd5, '0);
      do_txn(1'b0, 10'd5, '0, 1, ok, rq, rh, um, mw, ma, md, lat, st);
    end
    n_chk++; if (ifc_s.hit_cnt !== 2'(sat3(hits_m))) $display("FAIL sat_hit_cnt got %0d exp %0d", ifc_s.hit_cnt, sat3(hits_m)); else n_pass++;
    n_chk++; if (ifc_s.miss_cnt !== 2'(sat3(misses_m))) $display("FAIL sat_miss_cnt got %0d exp %0d", ifc_s.miss_cnt, sat3(misses_m)); else n_pass++;
    n_chk++; if (ifc.hit_cnt !== 16'(hits_m)) $display("FAIL wide_hit_cnt got %0d exp %0d", ifc.hit_cnt, hits_m); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, um, st; logic [31:0] rq, md; logic rh, mw; logic [9:0] ma; int lat, eh;
    ifc.req = 1'b1; ifc.wr = 1'b0; ifc.addr = 10'd9;
    @(posedge clk); #1;
    ifc.req = 1'b0;
    n_chk++; if (ifc.mem_req !== 1'b1) $display("FAIL rm_memreq got %b exp 1", ifc.mem_req); else n_pass++;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ifc.done, ifc.q, ifc.hit, ifc.mem_req, ifc.mem_wr, ifc.mem_addr, ifc.mem_wdata, ifc.hit_cnt, ifc.miss_cnt} !== '0)
      $display("FAIL rm_async_clear got q=%h mreq=%b maddr=%0d hc=%0d mc=%0d exp all 0",
               ifc.q, ifc.mem_req, ifc.mem_addr, ifc.hit_cnt, ifc.miss_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 32'h1234;
    @(posedge clk); #1;
    ifc.mem_ack = 1'b0;
    n_chk++; if ({ifc.done, ifc.mem_req, ifc.ready, ifc.miss_cnt} !== {1'b0, 1'b0, 1'b1, 16'd0})
      $display("FAIL rm_late_ack got done=%b mreq=%b ready=%b mc=%0d exp 0 0 1 0", ifc.done, ifc.mem_req, ifc.ready, ifc.miss_cnt);
    else n_pass++;
    eh = model_txn(1'b0, 10'd5, '0);
    do_txn(1'b0, 10'd5, '0, 2, ok, rq, rh, um, mw, ma, md, lat, st);
    n_chk++; if ({rh, um, rq} !== {1'(eh), 1'b1, mem[5]})
      $display("FAIL rm_reread got hit=%b memreq=%b q=%h exp %0d 1 %h", rh, um, rq, eh, mem[5]);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok, um, st, w; logic [31:0] rq, md, d; logic rh, mw; logic [9:0] ma, a; int lat, eh, dly;
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1)); a = 10'($urandom_range(0, 47)); d = $urandom; dly = $urandom_range(1, 4);
      eh = model_txn(w, a, d);
      do_txn(w, a, d, dly, ok, rq, rh, um, mw, ma, md, lat, st);
      n_chk++; if (!ok) $display("FAIL rnd_done i=%0d no done seen", i); else n_pass++;
      n_chk++; if (rh !== 1'(eh)) $display("FAIL rnd_hit i=%0d a=%0d w=%b got %b exp %0d", i, a, w, rh, eh); else n_pass++;
      n_chk++; if (um !== (w || !eh)) $display("FAIL rnd_memreq i=%0d got %b exp %b", i, um, (w || !eh)); else n_pass++;
      n_chk++; if (lat != ((w || !eh) ? dly + 1 : 1)) $display("FAIL rnd_latency i=%0d got %0d exp %0d", i, lat, (w || !eh) ? dly + 1 : 1); else n_pass++;
      if (!w) begin
        n_chk++; if (rq !== mem[a]) $display("FAIL rnd_q i=%0d a=%0d got %h exp %h", i, a, rq, mem[a]); else n_pass++;
      end
    end
    n_chk++; if ({ifc.hit_cnt, ifc.miss_cnt} !== {16'(hits_m), 16'(misses_m)})
      $display("FAIL rnd_counters got %0d/%0d exp %0d/%0d", ifc.hit_cnt, ifc.miss_cnt, hits_m, misses_m);
    else n_pass++;
    n_chk++; if ({ifc_s.hit_cnt, ifc_s.miss_cnt} !== {2'(sat3(hits_m)), 2'(sat3(misses_m))})
      $display("FAIL rnd_sat_counters got %0d/%0d exp %0d/%0d", ifc_s.hit_cnt, ifc_s.miss_cnt, sat3(hits_m), sat3(misses_m));
    else n_pass++;
  endtask

  initial begin
    ifc.req = 1'b0; ifc.wr = 1'b0; ifc.addr = '0; ifc.data = '0;
    ifc.mem_ack = 1'b0; ifc.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_write_miss();
    test_read_hit();
    test_cold_and_conflict();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
